// File: rtl/tmds_serializer_10_to_1.sv
// rtl/tmds_serializer_10_to_1.sv - 10:1 TMDS serializer with double buffer, idle fill, training and slip
// Optional: TMDS_SER_PRBS_EN adds input prbs_en and a 7-bit LFSR symbol source.
module tmds_serializer_10_to_1 #(
    parameter int unsigned      WIDTH      = 10,
    parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(10'b1101010100),
    parameter logic [WIDTH-1:0] TRAIN_WORD = WIDTH'(10'b0010101011)
) (
    input  logic             gclk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             train,
    input  logic             slip,
`ifdef TMDS_SER_PRBS_EN
    input  logic             prbs_en,
`endif
    output logic             serial_out,
    output logic             word_start,
    output logic             underflow
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    r_slip_off;
    logic             r_word_start;
    logic             r_underflow;
    logic             r_data_ready;

    logic             w_load;
    logic             w_accept;
    logic             w_consume;
    logic             w_use_idle;
    logic             w_hold_full_next;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_rot;

`ifdef TMDS_SER_PRBS_EN
    logic [6:0]       r_lfsr;
    logic [6:0]       w_lfsr_next;
    logic [WIDTH-1:0] w_prbs_word;

    // x^7+x^6+1, one output bit per step; bit 0 of the symbol is the first step
    always_comb begin
        w_lfsr_next = r_lfsr;
        w_prbs_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_prbs_word[i] = w_lfsr_next[6];
            w_lfsr_next    = {w_lfsr_next[5:0], w_lfsr_next[6] ^ w_lfsr_next[5]};
        end
    end

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= 7'h7F;
        end else if (w_load && prbs_en && !train) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`endif

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: if (enable) w_state_next = S_LOAD;
            S_LOAD: begin
                w_state_next = S_RUN;
                w_load       = 1'b1;
            end
            S_RUN:   w_load = (r_bit_cnt == CW'(WIDTH - 1));
            default: w_state_next = S_IDLE;
        endcase
        if (!enable) begin
            w_state_next = S_IDLE;
            w_load       = 1'b0;
        end
    end

    always_comb begin
        w_word     = IDLE_WORD;
        w_consume  = 1'b0;
        w_use_idle = 1'b0;
        if (train) begin
            w_word = TRAIN_WORD;
        end
`ifdef TMDS_SER_PRBS_EN
        else if (prbs_en) begin
            w_word = w_prbs_word;
        end
`endif
        else if (r_hold_full) begin
            w_word    = r_hold;
            w_consume = w_load;
        end else begin
            w_use_idle = w_load;
        end
    end

    // Slip only lands at a symbol load, so the boundary never moves mid-symbol
    assign w_rot            = WIDTH'({w_word, w_word} >> r_slip_off);
    assign w_accept         = data_valid && r_data_ready;
    assign w_hold_full_next = w_accept || (r_hold_full && !w_consume);

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_bit_cnt    <= '0;
            r_slip_off   <= '0;
            r_word_start <= 1'b0;
            r_underflow  <= 1'b0;
            r_data_ready <= 1'b0;
        end else begin
            r_word_start <= w_load;
            r_underflow  <= w_use_idle;
            if (w_load) begin
                r_shift   <= w_rot;
                r_bit_cnt <= '0;
            end else if (r_state == S_RUN && enable) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end else begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end
            if (w_accept) begin
                r_hold <= data_in;
            end
            r_hold_full <= w_hold_full_next;
            if (slip) begin
                r_slip_off <= (r_slip_off == CW'(WIDTH - 1)) ? '0 : r_slip_off + CW'(1);
            end
            r_data_ready <= !w_hold_full_next && (w_state_next == S_RUN);
        end
    end

    assign serial_out = r_shift[0];
    assign word_start = r_word_start;
    assign underflow  = r_underflow;
    assign data_ready = r_data_ready;

endmodule

// File: tb/tb_tmds_serializer_10_to_1.sv
// tb/tb_tmds_serializer_10_to_1.sv - directed self-checking bench for tmds_serializer_10_to_1
module tb_tmds_serializer_10_to_1;

    localparam logic [9:0] IDLE_W  = 10'b1101010100;
    localparam logic [9:0] TRAIN_W = 10'b0010101011;

    logic       gclk;
    logic       reset_n;
    logic       enable;
    logic [9:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       train;
    logic       slip;
    logic       serial_out;
    logic       word_start;
    logic       underflow;

    int total = 0;
    int bad   = 0;
    logic [9:0] src_q[$];

    tmds_serializer_10_to_1 dut (
        .gclk       (gclk),
        .reset_n    (reset_n),
        .enable     (enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .train      (train),
        .slip       (slip),
        .serial_out (serial_out),
        .word_start (word_start),
        .underflow  (underflow)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one cycle; the source pops its queue when the edge accepted a word
    task automatic tick();
        logic acc;
        acc = data_valid && data_ready;
        @(posedge gclk);
        #1;
        if (acc && src_q.size() > 0) begin
            void'(src_q.pop_front());
            if (src_q.size() > 0) data_in = src_q[0];
            else data_valid = 1'b0;
        end
    endtask

    task automatic start_src();
        if (src_q.size() > 0) begin
            data_in    = src_q[0];
            data_valid = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        train      = 1'b0;
        slip       = 1'b0;
        data_valid = 1'b0;
        data_in    = 10'h000;
        src_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic expect_sym(input string tag, input logic [9:0] w, input logic uf,
                              input logic [9:0] slip_mask);
        for (int i = 0; i < 10; i++) begin
            chk({tag, " bit"}, 16'(serial_out), 16'(w[i]));
            chk({tag, " word_start"}, 16'(word_start), 16'(i == 0));
            chk({tag, " underflow"}, 16'(underflow), 16'(uf && (i == 0)));
            slip = slip_mask[i];
            tick();
        end
        slip = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst serial_out", 16'(serial_out), 16'd0);
        chk("rst word_start", 16'(word_start), 16'd0);
        chk("rst underflow", 16'(underflow), 16'd0);
        chk("rst data_ready", 16'(data_ready), 16'd0);
        tick();
        chk("idle serial_out", 16'(serial_out), 16'd0);
        chk("idle data_ready", 16'(data_ready), 16'd0);

        // no data: repeated IDLE_WORD with underflow
        do_reset();
        enable = 1'b1;
        tick();
        chk("load serial_out", 16'(serial_out), 16'd0);
        chk("load data_ready", 16'(data_ready), 16'd0);
        tick();
        chk("run data_ready", 16'(data_ready), 16'd1);
        expect_sym("idle0", IDLE_W, 1'b1, 10'h0);
        expect_sym("idle1", IDLE_W, 1'b1, 10'h0);
        expect_sym("idle2", IDLE_W, 1'b1, 10'h0);

        // back-to-back stream
        do_reset();
        src_q = '{10'h3FF, 10'h000, 10'h155};
        start_src();
        enable = 1'b1;
        tick();
        tick();
        expect_sym("str idle", IDLE_W, 1'b1, 10'h0);
        expect_sym("str 3ff", 10'h3FF, 1'b0, 10'h0);
        expect_sym("str 000", 10'h000, 1'b0, 10'h0);
        expect_sym("str 155", 10'h155, 1'b0, 10'h0);
        expect_sym("str tail", IDLE_W, 1'b1, 10'h0);

        // training overrides a full holding register
        do_reset();
        src_q = '{10'h2AA};
        start_src();
        train  = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        expect_sym("trn0", TRAIN_W, 1'b0, 10'h0);
        expect_sym("trn1", TRAIN_W, 1'b0, 10'h0);
        train = 1'b0;
        expect_sym("trn2", TRAIN_W, 1'b0, 10'h0);
        expect_sym("trn held", 10'h2AA, 1'b0, 10'h0);
        expect_sym("trn tail", IDLE_W, 1'b1, 10'h0);

        // two slips mid-symbol rotate later symbols right by 2
        do_reset();
        src_q = '{10'h001, 10'h001, 10'h001, 10'h001};
        start_src();
        enable = 1'b1;
        tick();
        tick();
        expect_sym("slp idle", IDLE_W, 1'b1, 10'h0);
        expect_sym("slp w0", 10'h001, 1'b0, 10'h0);
        expect_sym("slp w1", 10'h001, 1'b0, 10'b0000101000);
        expect_sym("slp w2", 10'h100, 1'b0, 10'h0);
        expect_sym("slp w3", 10'h100, 1'b0, 10'h0);
        expect_sym("slp idle rot", 10'h0D5, 1'b1, 10'h0);

        // enable dropped at bit 4, held low 5 cycles
        do_reset();
        src_q = '{10'h2B5, 10'h0F3};
        start_src();
        enable = 1'b1;
        tick();
        tick();
        expect_sym("en idle", IDLE_W, 1'b1, 10'h0);
        for (int i = 0; i < 5; i++) begin
            chk("en partial bit", 16'(serial_out), 16'((10'h2B5 >> i) & 10'h1));
            if (i < 4) tick();
        end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("en off serial_out", 16'(serial_out), 16'd0);
            chk("en off word_start", 16'(word_start), 16'd0);
            chk("en off data_ready", 16'(data_ready), 16'd0);
        end
        enable = 1'b1;
        tick();
        chk("en reload serial_out", 16'(serial_out), 16'd0);
        tick();
        expect_sym("en held", 10'h0F3, 1'b0, 10'h0);
        expect_sym("en tail", IDLE_W, 1'b1, 10'h0);

        // asynchronous reset mid-symbol with a full holding register
        do_reset();
        src_q = '{10'h155, 10'h0CC};
        start_src();
        enable = 1'b1;
        tick();
        tick();
        expect_sym("ar idle", IDLE_W, 1'b1, 10'h0);
        tick();
        tick();
        tick();
        chk("ar pre bit3", 16'(serial_out), 16'd0);
        tick();
        chk("ar pre bit4", 16'(serial_out), 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar serial_out", 16'(serial_out), 16'd0);
        chk("ar word_start", 16'(word_start), 16'd0);
        chk("ar underflow", 16'(underflow), 16'd0);
        chk("ar data_ready", 16'(data_ready), 16'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        expect_sym("ar after", IDLE_W, 1'b1, 10'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
